id_pc_redirect: RTL
===================

Name: id_pc_redirect

Overview:
- Decode-stage end of the fetch/decode interface.
- Consumes the instruction and next-PC pair delivered by the fetch stage and resolves control transfers: branches, jumps, register jumps and the trap vector.
- Drives the registered redirect request back to fetch (PC source select, type and target operands).
- Squashes wrong-path instructions before they reach execute, passing an ID/EX instruction pair downstream.

Parameters:
- SQUASH_SLOTS, default 1: number of wrong-path instructions replaced by NOP after the redirect cycle (1..3).
- TRAP_VECTOR, default 32'h0000_0040: informational only; fetch supplies the vector when type is 2'b11.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_if_stall  in  1  pipeline freeze from execute.
- if_id_nextpc  in  32  PC+4 of if_id_instruc.
- if_id_instruc  in  32  instruction from fetch; 32'h0 = NOP.
- rs_data  in  32  register-file value of instr[25:21], same cycle.
- rt_data  in  32  register-file value of instr[20:16], same cycle.
- id_if_selpcsource  out  1  redirect request to fetch.
- id_if_selpctype  out  2  00 branch, 01 register, 10 jump index, 11 trap.
- id_if_pcimd2ext  out  32  branch target.
- id_if_rega  out  32  register jump target.
- id_if_pcindex  out  32  jump-index target.
- id_ex_instruc  out  32  instruction to execute (NOP when squashed).
- id_ex_nextpc  out  32  PC+4 of id_ex_instruc.
- id_ex_link  out  32  return address for JAL/JALR = nextpc+4; 0 otherwise.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state RUN, squash counter 0. Reset overrides stall and takes effect mid-redirect or mid-squash.
- Decode, opcode = instr[31:26]:
  - J 000010 / JAL 000011 → type 10, pcindex = {nextpc[31:28], instr[25:0], 2'b00}.
  - BEQ 000100 (taken if rs==rt) / BNE 000101 (taken if rs!=rt) → type 00, pcimd2ext = nextpc + ({{14{instr[15]}}, instr[15:0], 2'b00}), mod 2^32.
  - R-type 000000 with funct 001000 JR or 001001 JALR → type 01, rega = rs_data.
  - 111111 TRAP → type 11.
  - Not-taken branches and everything else: no redirect.
- Stall (ex_if_stall=1): every register holds, including state, counter and all outputs.
- State RUN:
  - Control transfer decoded → at the clock edge, register selpcsource=1 with type and target; go to REDIR.
  - The transfer instruction itself passes to id_ex_* the same edge.
  - Otherwise selpcsource=0 and the instruction passes through.
- State REDIR, one non-stalled cycle:
  - selpcsource stays 1 for exactly one non-stalled cycle. A stall during REDIR holds it high until a non-stalled cycle completes.
  - The instruction present in this cycle is the delay slot. It passes to EX unmodified and is never decoded as a transfer.
  - Next state is SQUASH with counter = SQUASH_SLOTS; selpcsource returns to 0.
- State SQUASH:
  - Each non-stalled cycle: id_ex_instruc=0, id_ex_nextpc=0, id_ex_link=0, counter decrements.
  - Any transfer arriving in this state is ignored.
  - Counter reaching 0 → RUN.
- Latency: decode to redirect visible at fetch = 1 cycle. ID/EX latency = 1 cycle.
- Target registers (pcimd2ext, rega, pcindex) update only on redirect and otherwise hold.
- id_ex_link = nextpc + 4 for JAL and JALR only.

Test Plan:
1. Reset: hold reset 2 cycles with instr=BEQ → all outputs 0, no redirect, state RUN.
2. BEQ taken: nextpc=0x100, imm=0xFFFE, rs=rt=5 → next cycle selpcsource=1, type=00, pcimd2ext=0x0F8. Delay slot passes through; following instruction squashed to 0; selpcsource low after one cycle.
3. BNE not taken: rs=rt=7 → selpcsource stays 0, instructions stream through unchanged. Then JAL with nextpc=0x2000_0010, index=0x40 → type=10, pcindex=0x2000_0100, id_ex_link=0x2000_0014.
4. JR with rs_data=0x1234, ex_if_stall asserted for 3 cycles during REDIR → selpcsource=1 and rega=0x1234 held for all 3 stall cycles plus 1; squash counter frozen during the stall.
5. TRAP opcode, then J in the delay slot, then BEQ in the squash slot → only one redirect (type=11). J reaches EX unmodified; BEQ replaced by 0.
6. Reset asserted mid-SQUASH with SQUASH_SLOTS=3 → next cycle outputs 0, state RUN. The next instruction passes through unsquashed.

Source files
------------

// File: rtl/id_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : id_pc_redirect
// Description : Decode-stage end of the fetch/decode interface. Resolves
//               branches, jumps, register jumps and traps, issues a
//               registered redirect request to fetch, lets the delay slot
//               through, and squashes the following wrong-path instructions
//               before they reach execute.
// Revision    : 1.0 - initial release
// ============================================================================
module id_pc_redirect #(
    parameter int          SQUASH_SLOTS = 1,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0040
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_if_stall,
    input  logic [31:0] if_id_nextpc,
    input  logic [31:0] if_id_instruc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcindex,
    output logic [31:0] id_ex_instruc,
    output logic [31:0] id_ex_nextpc,
    output logic [31:0] id_ex_link
);

    // Fetch owns the trap vector; the parameter only documents it. The
    // elaboration check keeps both parameters inside their meaningful range.
    if ((SQUASH_SLOTS < 1) || (SQUASH_SLOTS > 3) || (TRAP_VECTOR[1:0] != 2'b00)) begin : g_param_check
        $error("id_pc_redirect: SQUASH_SLOTS must be 1..3 and TRAP_VECTOR word aligned");
    end

    localparam logic [1:0] c_squash_slots = 2'(SQUASH_SLOTS);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_trap  = 6'b111111;
    localparam logic [5:0] c_fn_jr    = 6'b001000;
    localparam logic [5:0] c_fn_jalr  = 6'b001001;

    localparam logic [1:0] c_type_branch = 2'b00;
    localparam logic [1:0] c_type_reg    = 2'b01;
    localparam logic [1:0] c_type_index  = 2'b10;
    localparam logic [1:0] c_type_trap   = 2'b11;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REDIR  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        selpcsource_q, selpcsource_d;
    logic [1:0]  selpctype_q, selpctype_d;
    logic [31:0] pcimd2ext_q, pcimd2ext_d;
    logic [31:0] rega_q, rega_d;
    logic [31:0] pcindex_q, pcindex_d;
    logic [31:0] ex_instruc_q, ex_instruc_d;
    logic [31:0] ex_nextpc_q, ex_nextpc_d;
    logic [31:0] ex_link_q, ex_link_d;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_is_jump;
    logic        w_is_jal;
    logic        w_is_reg_jump;
    logic        w_is_jalr;
    logic        w_is_trap;
    logic        w_br_taken;
    logic        w_transfer;
    logic [1:0]  w_type;
    logic [31:0] w_br_target;
    logic [31:0] w_idx_target;
    logic [31:0] w_link;

    // Decode the instruction currently offered by fetch.
    always_comb begin
        w_op          = if_id_instruc[31:26];
        w_funct       = if_id_instruc[5:0];
        w_is_jump     = (w_op == c_op_j) || (w_op == c_op_jal);
        w_is_jal      = (w_op == c_op_jal);
        w_is_jalr     = (w_op == c_op_rtype) && (w_funct == c_fn_jalr);
        w_is_reg_jump = (w_op == c_op_rtype) && ((w_funct == c_fn_jr) || w_is_jalr);
        w_is_trap     = (w_op == c_op_trap);
        w_br_taken    = ((w_op == c_op_beq) && (rs_data == rt_data)) ||
                        ((w_op == c_op_bne) && (rs_data != rt_data));
        w_transfer    = w_is_jump || w_br_taken || w_is_reg_jump || w_is_trap;
        w_br_target   = if_id_nextpc + {{14{if_id_instruc[15]}}, if_id_instruc[15:0], 2'b00};
        w_idx_target  = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};
        w_link        = (w_is_jal || w_is_jalr) ? (if_id_nextpc + 32'd4) : 32'd0;
        w_type        = c_type_branch;
        if (w_is_jump) begin
            w_type = c_type_index;
        end else if (w_is_reg_jump) begin
            w_type = c_type_reg;
        end else if (w_is_trap) begin
            w_type = c_type_trap;
        end
    end

    // Next-state and next-output logic; a stall leaves every register as is.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        selpcsource_d = selpcsource_q;
        selpctype_d   = selpctype_q;
        pcimd2ext_d   = pcimd2ext_q;
        rega_d        = rega_q;
        pcindex_d     = pcindex_q;
        ex_instruc_d  = ex_instruc_q;
        ex_nextpc_d   = ex_nextpc_q;
        ex_link_d     = ex_link_q;

        if (!ex_if_stall) begin
            case (state_q)
                RUN: begin
                    ex_instruc_d  = if_id_instruc;
                    ex_nextpc_d   = if_id_nextpc;
                    ex_link_d     = w_link;
                    selpcsource_d = w_transfer;
                    if (w_transfer) begin
                        selpctype_d = w_type;
                        state_d     = REDIR;
                        // Only the target that fetch will consume is refreshed.
                        case (w_type)
                            c_type_branch: pcimd2ext_d = w_br_target;
                            c_type_reg:    rega_d      = rs_data;
                            c_type_index:  pcindex_d   = w_idx_target;
                            default:       ;
                        endcase
                    end
                end
                REDIR: begin
                    // Delay slot: forwarded untouched, never treated as a transfer.
                    ex_instruc_d  = if_id_instruc;
                    ex_nextpc_d   = if_id_nextpc;
                    ex_link_d     = w_link;
                    selpcsource_d = 1'b0;
                    cnt_d         = c_squash_slots;
                    state_d       = SQUASH;
                end
                SQUASH: begin
                    ex_instruc_d  = 32'd0;
                    ex_nextpc_d   = 32'd0;
                    ex_link_d     = 32'd0;
                    selpcsource_d = 1'b0;
                    cnt_d         = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d       = RUN;
                    cnt_d         = 2'd0;
                    selpcsource_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset dominating stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= 2'd0;
            selpcsource_q <= 1'b0;
            selpctype_q   <= 2'b00;
            pcimd2ext_q   <= 32'd0;
            rega_q        <= 32'd0;
            pcindex_q     <= 32'd0;
            ex_instruc_q  <= 32'd0;
            ex_nextpc_q   <= 32'd0;
            ex_link_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            selpcsource_q <= selpcsource_d;
            selpctype_q   <= selpctype_d;
            pcimd2ext_q   <= pcimd2ext_d;
            rega_q        <= rega_d;
            pcindex_q     <= pcindex_d;
            ex_instruc_q  <= ex_instruc_d;
            ex_nextpc_q   <= ex_nextpc_d;
            ex_link_q     <= ex_link_d;
        end
    end

    assign id_if_selpcsource = selpcsource_q;
    assign id_if_selpctype   = selpctype_q;
    assign id_if_pcimd2ext   = pcimd2ext_q;
    assign id_if_rega        = rega_q;
    assign id_if_pcindex     = pcindex_q;
    assign id_ex_instruc     = ex_instruc_q;
    assign id_ex_nextpc      = ex_nextpc_q;
    assign id_ex_link        = ex_link_q;

endmodule
`default_nettype wire
